// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between the
// MEM stage and data_memory; one word per line, hit/miss counters for perf checks.
module dcache_direct_mapped #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_read,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_ctrl,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_we,
    output logic [2:0]            mem_ctrl,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    input  logic                  mem_ready,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];
    logic [31:0]           r_hit_cnt;
    logic [31:0]           r_miss_cnt;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_lane;
    logic                  w_hit;
    logic                  w_sb;
    logic                  w_load_hit;
    logic                  w_load_miss;
    logic                  w_fill_wr;
    logic                  w_store_wr;
    logic [DATA_WIDTH-1:0] w_line;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_byte(
        input logic [DATA_WIDTH-1:0] word, input logic [1:0] lane, input logic [7:0] b);
        logic [DATA_WIDTH-1:0] res;
        res = word;
        res[lane*8 +: 8] = b;
        return res;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fmt_load(
        input logic [DATA_WIDTH-1:0] word, input logic [2:0] ctrl, input logic [1:0] lane);
        logic [7:0] b;
        b = word[lane*8 +: 8];
        case (ctrl)
            3'b000:  return {{(DATA_WIDTH-8){b[7]}}, b};
            3'b011:  return {{(DATA_WIDTH-8){1'b0}}, b};
            default: return word;
        endcase
    endfunction

    assign w_index     = cpu_addr[INDEX_BITS+1:2];
    assign w_tag       = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_lane      = cpu_addr[1:0];
    assign w_line      = r_data[w_index];
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_sb        = (cpu_ctrl == 3'b000);
    assign w_load_hit  = (r_state == IDLE) && cpu_read && !cpu_we && w_hit;
    assign w_load_miss = (r_state == IDLE) && cpu_read && !cpu_we && !w_hit;
    assign w_fill_wr   = !rst && (r_state == FILL) && mem_ready;
    assign w_store_wr  = !rst && (r_state == WRITE) && mem_ready && w_hit;

    assign stall      = !rst && (cpu_read || cpu_we) && !w_load_hit && (r_state != DONE);
    assign cpu_rd     = (!rst && w_hit) ? fmt_load(w_line, cpu_ctrl, w_lane) : '0;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_fill_wr)
                r_valid[w_index] <= 1'b1;
            if (w_load_hit)
                r_hit_cnt <= sat_inc(r_hit_cnt);
            if (w_load_miss)
                r_miss_cnt <= sat_inc(r_miss_cnt);
        end
    end

    // Tag/data arrays carry no reset; r_valid alone decides whether a line is live.
    always_ff @(posedge clk) begin
        if (w_fill_wr) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= mem_rd;
        end else if (w_store_wr) begin
            r_data[w_index] <= w_sb ? merge_byte(w_line, w_lane, cpu_wd[7:0]) : cpu_wd;
        end
    end

    always_comb begin
        w_next   = r_state;
        mem_read = 1'b0;
        mem_we   = 1'b0;
        mem_addr = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_ctrl = 3'b010;
        mem_wd   = '0;
        case (r_state)
            IDLE: begin
                if (cpu_we)
                    w_next = WRITE;
                else if (cpu_read && !w_hit)
                    w_next = FILL;
            end
            FILL: begin
                mem_read = 1'b1;
                if (mem_ready)
                    w_next = DONE;
            end
            WRITE: begin
                mem_we   = 1'b1;
                mem_addr = cpu_addr;
                mem_wd   = cpu_wd;
                mem_ctrl = w_sb ? 3'b000 : 3'b010;
                if (mem_ready)
                    w_next = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
        endcase
        if (rst) begin
            mem_read = 1'b0;
            mem_we   = 1'b0;
            mem_wd   = '0;
        end
    end
endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: vector table through a scoreboard queue, a
// word-addressed memory model with programmable latency, plus reset corner cases.
module tb_dcache_direct_mapped;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_read;
    logic        cpu_we;
    logic [2:0]  cpu_ctrl;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        stall;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_we;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dcache_direct_mapped #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_we(cpu_we),
        .cpu_ctrl(cpu_ctrl), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_we(mem_we),
        .mem_ctrl(mem_ctrl), .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] wd;
        int          lat;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_stalls;
        logic [31:0] exp_hit;
        logic [31:0] exp_miss;
    } vec_t;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        int          stalls;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    int          g_lat = 0;
    bit          mem_hold = 1'b0;
    logic [31:0] mem [int];
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    logic [2:0]  last_wc = 3'b111;

    function automatic int mkey(input logic [31:0] a);
        return int'(a >> 2);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder: raises mem_ready for one cycle after g_lat waiting cycles.
    initial begin
        int          cnt;
        logic [31:0] w;
        logic [1:0]  ln;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rd    = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && !mem_hold && (mem_read || mem_we)) begin
                if (cnt >= g_lat) begin
                    mem_ready = 1'b1;
                    cnt = 0;
                    if (mem_read) begin
                        mem_rd = mem.exists(mkey(mem_addr)) ? mem[mkey(mem_addr)] : 32'h0;
                    end else begin
                        w  = mem.exists(mkey(mem_addr)) ? mem[mkey(mem_addr)] : 32'h0;
                        ln = mem_addr[1:0];
                        if (mem_ctrl == 3'b000)
                            w[ln*8 +: 8] = mem_wd[7:0];
                        else
                            w = mem_wd;
                        mem[mkey(mem_addr)] = w;
                        last_wa = mem_addr;
                        last_wd = mem_wd;
                        last_wc = mem_ctrl;
                    end
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic add_vec(input logic [31:0] a, input logic r, input logic we, input logic [2:0] c,
                           input logic [31:0] wd, input int lat, input logic chk,
                           input logic [31:0] erd, input int est, input int eh, input int em);
        vec_t v;
        v = '{a, r, we, c, wd, lat, chk, erd, est, 32'(eh), 32'(em)};
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        exp_t        pend;
        int          st;
        bit          done;
        logic [31:0] rdv;
        @(posedge clk);
        #1;
        g_lat    = v.lat;
        cpu_addr = v.addr;
        cpu_read = v.rd;
        cpu_we   = v.we;
        cpu_ctrl = v.ctrl;
        cpu_wd   = v.wd;
        pend = '{v.chk_rd, v.exp_rd, v.exp_stalls};
        sb_q.push_back(pend);
        st = 0;
        done = 1'b0;
        rdv = '0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                rdv  = cpu_rd;
            end else begin
                st++;
            end
        end
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        cpu_we   = 1'b0;
        e = sb_q.pop_front();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL vec%0d timeout: stall still high after 60 cycles, expected completion", idx);
        end else begin
            check32($sformatf("vec%0d stall_cycles", idx), 32'(st), 32'(e.stalls));
            if (e.chk_rd)
                check32($sformatf("vec%0d cpu_rd", idx), rdv, e.rd);
        end
        check32($sformatf("vec%0d hit_count", idx), hit_count, v.exp_hit);
        check32($sformatf("vec%0d miss_count", idx), miss_count, v.exp_miss);
        if (v.we) begin
            check32($sformatf("vec%0d mem_addr_wr", idx), last_wa, v.addr);
            check32($sformatf("vec%0d mem_wd_wr", idx), last_wd, v.wd);
            check32($sformatf("vec%0d mem_ctrl_wr", idx), 32'(last_wc),
                    (v.ctrl == 3'b000) ? 32'd0 : 32'd2);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[mkey(32'h0001_0000)] = 32'hDEAD_BEEF;
        mem[mkey(32'h0001_0400)] = 32'h1234_5678;
        rst      = 1'b1;
        cpu_addr = '0;
        cpu_read = 1'b0;
        cpu_we   = 1'b0;
        cpu_ctrl = 3'b010;
        cpu_wd   = '0;
        repeat (2) @(posedge clk);
        #1;
        check32("rst stall", 32'(stall), 32'd0);
        check32("rst mem_read", 32'(mem_read), 32'd0);
        check32("rst mem_we", 32'(mem_we), 32'd0);
        check32("rst cpu_rd", cpu_rd, 32'd0);
        check32("rst mem_wd", mem_wd, 32'd0);
        check32("rst hit_count", hit_count, 32'd0);
        check32("rst miss_count", miss_count, 32'd0);
        rst = 1'b0;

        //      addr          rd    we    ctrl    wd            lat chk   exp_rd        st hit miss
        add_vec(32'h0001_0000, 1'b1, 1'b0, 3'b010, 32'h0,         0, 1'b1, 32'hDEADBEEF, 2, 0, 1);
        add_vec(32'h0001_0000, 1'b1, 1'b0, 3'b010, 32'h0,         0, 1'b1, 32'hDEADBEEF, 0, 1, 1);
        add_vec(32'h0001_0003, 1'b1, 1'b0, 3'b000, 32'h0,         0, 1'b1, 32'hFFFFFFDE, 0, 2, 1);
        add_vec(32'h0001_0003, 1'b1, 1'b0, 3'b011, 32'h0,         0, 1'b1, 32'h000000DE, 0, 3, 1);
        add_vec(32'h0001_0000, 1'b1, 1'b0, 3'b000, 32'h0,         0, 1'b1, 32'hFFFFFFEF, 0, 4, 1);
        add_vec(32'h0001_0001, 1'b1, 1'b0, 3'b011, 32'h0,         0, 1'b1, 32'h000000BE, 0, 5, 1);
        add_vec(32'h0001_0001, 1'b0, 1'b1, 3'b000, 32'h77,        1, 1'b0, 32'h0,        3, 5, 1);
        add_vec(32'h0001_0000, 1'b1, 1'b0, 3'b010, 32'h0,         0, 1'b1, 32'hDEAD77EF, 0, 6, 1);
        add_vec(32'h0001_0400, 1'b1, 1'b0, 3'b010, 32'h0,         2, 1'b1, 32'h12345678, 4, 6, 2);
        add_vec(32'h0001_0000, 1'b1, 1'b0, 3'b010, 32'h0,         0, 1'b1, 32'hDEAD77EF, 2, 6, 3);
        add_vec(32'h0001_0400, 1'b0, 1'b1, 3'b010, 32'hCAFEF00D,  0, 1'b0, 32'h0,        2, 6, 3);
        add_vec(32'h0001_0400, 1'b1, 1'b0, 3'b010, 32'h0,         0, 1'b1, 32'hCAFEF00D, 2, 6, 4);
        add_vec(32'h0001_0400, 1'b0, 1'b1, 3'b010, 32'h0BADF00D,  0, 1'b0, 32'h0,        2, 6, 4);
        add_vec(32'h0001_0400, 1'b1, 1'b0, 3'b010, 32'h0,         0, 1'b1, 32'h0BADF00D, 0, 7, 4);
        add_vec(32'h0001_0000, 1'b1, 1'b0, 3'b010, 32'h0,         0, 1'b1, 32'hDEAD77EF, 2, 7, 5);
        add_vec(32'h0001_0000, 1'b1, 1'b1, 3'b010, 32'h11223344,  0, 1'b0, 32'h0,        2, 7, 5);
        add_vec(32'h0001_0000, 1'b1, 1'b0, 3'b010, 32'h0,         0, 1'b1, 32'h11223344, 0, 8, 5);

        foreach (vecs[i])
            run_vec(i, vecs[i]);

        // Reset while a fill is outstanding must abort it and drop every line.
        mem_hold = 1'b1;
        @(posedge clk);
        #1;
        cpu_addr = 32'h0001_0800;
        cpu_ctrl = 3'b010;
        cpu_read = 1'b1;
        repeat (3) @(negedge clk);
        check32("fill mem_read", 32'(mem_read), 32'd1);
        check32("fill mem_addr", mem_addr, 32'h0001_0800);
        check32("fill stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check32("abort mem_read", 32'(mem_read), 32'd0);
        check32("abort mem_we", 32'(mem_we), 32'd0);
        check32("abort cpu_rd", cpu_rd, 32'd0);
        check32("abort hit_count", hit_count, 32'd0);
        check32("abort miss_count", miss_count, 32'd0);
        rst      = 1'b0;
        cpu_read = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        check32("post-abort mem_read", 32'(mem_read), 32'd0);
        run_vec(100, '{32'h0001_0000, 1'b1, 1'b0, 3'b010, 32'h0, 0, 1'b1,
                       32'h11223344, 2, 32'd0, 32'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
